// File: rtl/mem_wb.sv
// mem_wb: mem/write-back pipeline register with load formatting and retired-instruction counter
module mem_wb #(
  parameter logic [31:0] NOP_INST = 32'h0000_0013,
  parameter logic [6:0]  LOAD_OPC = 7'b0000011
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        valid_i,
  input  logic [31:0] inst_i,
  input  logic [31:0] instaddr_i,
  input  logic        regs_wen_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic [1:0]  mem_addr_lo_i,
  input  logic        hold_i,
  input  logic        flush_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] instaddr_o,
  output logic        regs_wen_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        misalign_o,
  output logic [63:0] instret_o
);
  logic        valid_q, valid_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] instaddr_q, instaddr_d;
  logic        wen_q, wen_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        mis_q, mis_d;
  logic [63:0] instret_q, instret_d;
  logic [2:0]  f3;
  logic        is_load, mis, rsv;
  logic [7:0]  lb;
  logic [15:0] lh;
  logic [31:0] fmt;
  // Load lane selection, extension and fault classification of the incoming instruction
  always_comb begin
    f3 = inst_i[14:12];
    is_load = inst_i[6:0] == LOAD_OPC;
    lb = 8'(rd_data_i >> {mem_addr_lo_i, 3'b000});
    lh = mem_addr_lo_i[1] ? rd_data_i[31:16] : rd_data_i[15:0];
    mis = is_load & (((f3[1:0] == 2'b01) & mem_addr_lo_i[0]) | ((f3 == 3'b010) & (mem_addr_lo_i != 2'b00)));
    rsv = is_load & ((f3 == 3'b011) | (f3[2:1] == 2'b11));
    fmt = !is_load       ? rd_data_i :
          (mis | rsv)    ? 32'h0 :
          (f3 == 3'b000) ? {{24{lb[7]}}, lb} :
          (f3 == 3'b100) ? {24'h0, lb} :
          (f3 == 3'b001) ? {{16{lh[15]}}, lh} :
          (f3 == 3'b101) ? {16'h0, lh} :
                           rd_data_i;
  end
  // Next-state: flush or invalid capture inserts a bubble, hold freezes all but the misalign pulse
  always_comb begin
    valid_d = valid_q;
    inst_d = inst_q;
    instaddr_d = instaddr_q;
    wen_d = wen_q;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    mis_d = 1'b0;
    instret_d = instret_q;
    if (flush_i || (!hold_i && !valid_i)) begin
      valid_d = 1'b0;
      inst_d = NOP_INST;
      instaddr_d = 32'h0;
      wen_d = 1'b0;
      rd_addr_d = 5'h0;
      rd_data_d = 32'h0;
    end else if (!hold_i) begin
      valid_d = 1'b1;
      inst_d = inst_i;
      instaddr_d = instaddr_i;
      wen_d = regs_wen_i & (rd_addr_i != 5'h0) & !mis & !rsv;
      rd_addr_d = rd_addr_i;
      rd_data_d = fmt;
      mis_d = mis;
      instret_d = instret_q + {63'h0, !mis};
    end
  end
  // State register with synchronous active-low reset to the bubble state
  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid_q <= 1'b0;
      inst_q <= NOP_INST;
      instaddr_q <= 32'h0;
      wen_q <= 1'b0;
      rd_addr_q <= 5'h0;
      rd_data_q <= 32'h0;
      mis_q <= 1'b0;
      instret_q <= 64'h0;
    end else begin
      valid_q <= valid_d;
      inst_q <= inst_d;
      instaddr_q <= instaddr_d;
      wen_q <= wen_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
      mis_q <= mis_d;
      instret_q <= instret_d;
    end
  end
  assign valid_o = valid_q;
  assign inst_o = inst_q;
  assign instaddr_o = instaddr_q;
  assign regs_wen_o = wen_q;
  assign rd_addr_o = rd_addr_q;
  assign rd_data_o = rd_data_q;
  assign misalign_o = mis_q;
  assign instret_o = instret_q;
endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: scoreboard bench for mem_wb against a behavioural model
module tb_mem_wb;
  logic        clk = 1'b0;
  logic        rstn, valid_i, regs_wen_i, hold_i, flush_i;
  logic [31:0] inst_i, instaddr_i, rd_data_i;
  logic [4:0]  rd_addr_i;
  logic [1:0]  mem_addr_lo_i;
  logic        valid_o, regs_wen_o, misalign_o;
  logic [31:0] inst_o, instaddr_o, rd_data_o;
  logic [4:0]  rd_addr_o;
  logic [63:0] instret_o;

  typedef struct packed {
    logic        v;
    logic [31:0] inst;
    logic [31:0] pc;
    logic        wen;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        mis;
    logic [63:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   n_cmp = 0;
  int   n_err = 0;
  string tag = "reset";

  mem_wb dut (
    .clk(clk), .rstn(rstn), .valid_i(valid_i), .inst_i(inst_i), .instaddr_i(instaddr_i),
    .regs_wen_i(regs_wen_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i),
    .mem_addr_lo_i(mem_addr_lo_i), .hold_i(hold_i), .flush_i(flush_i),
    .valid_o(valid_o), .inst_o(inst_o), .instaddr_o(instaddr_o), .regs_wen_o(regs_wen_o),
    .rd_addr_o(rd_addr_o), .rd_data_o(rd_data_o), .misalign_o(misalign_o), .instret_o(instret_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
    return {17'h0, f3, rd, opc};
  endfunction

  function automatic exp_t bubble(input logic [63:0] cnt);
    exp_t e;
    e = '0;
    e.inst = 32'h0000_0013;
    e.cnt = cnt;
    return e;
  endfunction

  // Reference: spec rules computed arithmetically on the architectural view of a load
  function automatic exp_t model(input exp_t prev, input logic r, input logic v, input logic [31:0] inst,
                                 input logic [31:0] pc, input logic wen, input logic [4:0] rd,
                                 input logic [31:0] data, input int a, input logic h, input logic f);
    exp_t e;
    int f3;
    logic ld, mis, rsv;
    logic [31:0] bt, hw, val;
    if (!r) return bubble(64'h0);
    if (f) return bubble(prev.cnt);
    if (h) begin e = prev; e.mis = 1'b0; return e; end
    if (!v) return bubble(prev.cnt);
    f3 = int'(inst[14:12]);
    ld = inst[6:0] == 7'd3;
    bt = (data / (32'd1 << (8 * a))) % 32'd256;
    hw = (data / (32'd1 << (16 * (a / 2)))) % 32'd65536;
    mis = ld && ((((f3 == 1) || (f3 == 5)) && (a % 2 == 1)) || ((f3 == 2) && (a != 0)));
    rsv = ld && ((f3 == 3) || (f3 == 6) || (f3 == 7));
    if (!ld) val = data;
    else if (mis || rsv) val = 0;
    else if (f3 == 0) val = (bt >= 128) ? bt - 256 : bt;
    else if (f3 == 4) val = bt;
    else if (f3 == 1) val = (hw >= 32768) ? hw - 65536 : hw;
    else if (f3 == 5) val = hw;
    else val = data;
    e.v = 1'b1;
    e.inst = inst;
    e.pc = pc;
    e.wen = wen && (rd != 0) && !mis && !rsv;
    e.rd = rd;
    e.data = val;
    e.mis = mis;
    e.cnt = mis ? prev.cnt : prev.cnt + 64'd1;
    return e;
  endfunction

  task automatic step(input logic r, input logic v, input logic [31:0] inst, input logic [31:0] pc,
                      input logic wen, input logic [4:0] rd, input logic [31:0] data, input logic [1:0] a,
                      input logic h, input logic f);
    @(negedge clk);
    rstn = r; valid_i = v; inst_i = inst; instaddr_i = pc; regs_wen_i = wen;
    rd_addr_i = rd; rd_data_i = data; mem_addr_lo_i = a; hold_i = h; flush_i = f;
    cur = model(cur, r, v, inst, pc, wen, rd, data, int'(a), h, f);
    exp_q.push_back(cur);
  endtask

  task automatic ld(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] data);
    step(1, 1, mk(7'd3, f3, 5'd7), 32'h100, 1, 5'd7, data, a, 0, 0);
  endtask

  // Monitor: every edge the DUT presents a full output set; pop and compare
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = {valid_o, inst_o, instaddr_o, regs_wen_o, rd_addr_o, rd_data_o, misalign_o, instret_o};
      n_cmp++;
      if (g !== e) begin
        n_err++;
        $display("FAIL %s: got v=%b inst=%h pc=%h wen=%b rd=%0d data=%h mis=%b cnt=%h; want v=%b inst=%h pc=%h wen=%b rd=%0d data=%h mis=%b cnt=%h",
                 tag, g.v, g.inst, g.pc, g.wen, g.rd, g.data, g.mis, g.cnt,
                 e.v, e.inst, e.pc, e.wen, e.rd, e.data, e.mis, e.cnt);
      end
    end
  end

  initial begin
    cur = bubble(64'h0);
    rstn = 0; valid_i = 0; inst_i = 0; instaddr_i = 0; regs_wen_i = 0;
    rd_addr_i = 0; rd_data_i = 0; mem_addr_lo_i = 0; hold_i = 0; flush_i = 0;
    repeat (2) step(0, 1, $urandom, $urandom, 1, 5'($urandom), $urandom, 2'($urandom), 1'($urandom), 1'($urandom));
    tag = "first_capture";
    step(1, 1, mk(7'h13, 3'd0, 5'd1), 32'h4, 1, 5'd1, 32'hAB, 0, 0, 0);
    tag = "loads";
    for (int i = 0; i < 4; i++) ld(3'b000, 2'(i), 32'h80FF7F01);
    ld(3'b100, 2'd3, 32'h80FF7F01);
    ld(3'b001, 2'd2, 32'h80FF7F01);
    ld(3'b101, 2'd0, 32'h80FF7F01);
    ld(3'b010, 2'd0, 32'h80FF7F01);
    tag = "misaligned";
    step(1, 1, mk(7'd3, 3'b010, 5'd5), 32'h200, 1, 5'd5, 32'hDEADBEEF, 2'b01, 0, 0);
    step(1, 1, mk(7'h13, 3'd0, 5'd6), 32'h204, 1, 5'd6, 32'h55, 0, 0, 0);
    step(1, 1, mk(7'd3, 3'b001, 5'd5), 32'h208, 1, 5'd5, 32'hDEADBEEF, 2'b11, 0, 0);
    step(1, 1, mk(7'd3, 3'b110, 5'd5), 32'h20C, 1, 5'd5, 32'hDEADBEEF, 2'b00, 0, 0);
    tag = "hold_flush";
    step(1, 1, mk(7'h13, 3'd0, 5'd3), 32'h300, 1, 5'd3, 32'h1234, 0, 0, 0);
    repeat (3) step(1, 1, $urandom, $urandom, 1, 5'($urandom), $urandom, 2'($urandom), 1, 0);
    step(1, 1, $urandom, $urandom, 1, 5'($urandom), $urandom, 2'($urandom), 1, 1);
    tag = "mis_then_hold";
    step(1, 1, mk(7'd3, 3'b101, 5'd9), 32'h400, 1, 5'd9, 32'h1, 2'b01, 0, 0);
    step(1, 1, 32'h13, 32'h404, 1, 5'd9, 32'h2, 0, 1, 0);
    tag = "x0";
    step(1, 1, mk(7'h13, 3'd0, 5'd0), 32'h500, 1, 5'd0, 32'h77, 0, 0, 0);
    tag = "wrap";
    @(posedge clk);
    #2;
    force dut.instret_q = 64'hFFFF_FFFF_FFFF_FFFF;
    #1;
    release dut.instret_q;
    cur.cnt = 64'hFFFF_FFFF_FFFF_FFFF;
    step(1, 1, mk(7'h13, 3'd0, 5'd2), 32'h600, 1, 5'd2, 32'h9, 0, 0, 0);
    step(1, 1, mk(7'h13, 3'd0, 5'd2), 32'h604, 1, 5'd2, 32'hA, 0, 0, 0);
    tag = "random";
    for (int i = 0; i < 400; i++) begin
      logic [6:0] opc;
      int s;
      s = int'($urandom_range(0, 9));
      opc = (s < 5) ? 7'd3 : (s < 8) ? 7'h13 : 7'($urandom);
      step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0,
           {17'($urandom), 3'($urandom), 5'($urandom), opc}, $urandom, 1'($urandom),
           ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom), $urandom, 2'($urandom),
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_err++;
      $display("FAIL drain: %0d expected outputs never compared, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
